// File: rtl/uart_tx_ctrl_if.sv
// Handshake and output-stage bundle between a UART TX requester and the
// frame-sequencing controller.
interface uart_tx_ctrl_if;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] mux_sel;
    logic       busy;
    logic       ser_load;
    logic       ser_shift;
    logic       par_typ_q;

    modport master (
        output DATA_VALID, PAR_EN, PAR_TYP,
        input  mux_sel, busy, ser_load, ser_shift, par_typ_q
    );

    modport slave (
        input  DATA_VALID, PAR_EN, PAR_TYP,
        output mux_sel, busy, ser_load, ser_shift, par_typ_q
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits, optional parity,
// stop. One frame bit per CLK cycle; back-to-back frames accepted from STOP.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          par_en_r;
    logic          par_en_next_s;
    logic          par_typ_r;
    logic          par_typ_next_s;
    logic [1:0]    mux_sel_r;
    logic          busy_r;
    logic          shift_r;
    logic          accept_s;

    // Output decode per state, packed as {mux_sel, busy, ser_shift}; applied to
    // the next state so the registered outputs line up with state_r.
    function automatic logic [3:0] decode_out(input state_t st);
        logic [3:0] res;
        case (st)
            ST_IDLE:   res = 4'b11_0_0;
            ST_START:  res = 4'b00_1_0;
            ST_DATA:   res = 4'b01_1_1;
            ST_PARITY: res = 4'b10_1_0;
            ST_STOP:   res = 4'b11_1_0;
            default:   res = 4'b11_0_0;
        endcase
        return res;
    endfunction

    // A request is only taken between frames; RST gates it so ser_load is
    // low for the whole reset period regardless of DATA_VALID.
    assign accept_s = RST & bus.DATA_VALID &
                      ((state_r == ST_IDLE) || (state_r == ST_STOP));

    // Next-state, bit counter and parity-setting logic
    always_comb begin
        next_state_s   = state_r;
        cnt_next_s     = cnt_r;
        par_en_next_s  = par_en_r;
        par_typ_next_s = par_typ_r;
        case (state_r)
            ST_IDLE, ST_STOP: begin
                if (accept_s) begin
                    next_state_s   = ST_START;
                    par_en_next_s  = bus.PAR_EN;
                    par_typ_next_s = bus.PAR_TYP;
                end else begin
                    next_state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_DATA;
                cnt_next_s   = CNT_ZERO;
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (par_en_r) begin
                        next_state_s = ST_PARITY;
                    end else begin
                        next_state_s = ST_STOP;
                    end
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                next_state_s = ST_STOP;
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, latched parity settings and registered Moore outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            mux_sel_r <= 2'b11;
            busy_r    <= 1'b0;
            shift_r   <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            par_en_r  <= par_en_next_s;
            par_typ_r <= par_typ_next_s;
            {mux_sel_r, busy_r, shift_r} <= decode_out(next_state_s);
        end
    end

    assign bus.mux_sel   = mux_sel_r;
    assign bus.busy      = busy_r;
    assign bus.ser_shift = shift_r;
    assign bus.ser_load  = accept_s;
    assign bus.par_typ_q = par_typ_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: segment table of input stimulus, a
// frame-position reference model feeding a scoreboard, and per-frame totals.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic clk;
    logic rst_n;

    uart_tx_ctrl_if bus_if ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic dv;
        logic pe;
        logic pt;
        int   n;
        bit   clr;
        int   exp_busy;
        int   exp_shift;
    } seg_t;

    typedef struct {
        logic [1:0] mux;
        logic       busy;
        logic       load;
        logic       shift;
        logic       ptq;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int busy_cnt   = 0;
    int shift_cnt  = 0;

    // Reference model: position within frame (0 = idle, 1 = start, ..., m_len = stop)
    int   m_pos = 0;
    int   m_len = DW + 2;
    logic m_ptq = 1'b0;

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL cyc %0d %s: got %0d want %0d", cyc, name, got, want);
        end
    endtask

    task automatic step(input logic r, input logic dv, input logic pe, input logic pt);
        exp_t e;
        exp_t g;
        @(negedge clk);
        cyc++;
        rst_n             = r;
        bus_if.DATA_VALID = dv;
        bus_if.PAR_EN     = pe;
        bus_if.PAR_TYP    = pt;
        if (!r) begin
            m_pos = 0;
            m_ptq = 1'b0;
        end
        e.ptq   = m_ptq;
        e.shift = 1'b0;
        if (m_pos == 0) begin
            e.mux = 2'b11; e.busy = 1'b0;
        end else if (m_pos == 1) begin
            e.mux = 2'b00; e.busy = 1'b1;
        end else if (m_pos <= DW + 1) begin
            e.mux = 2'b01; e.busy = 1'b1; e.shift = 1'b1;
        end else if (m_pos == DW + 2 && m_len == DW + 3) begin
            e.mux = 2'b10; e.busy = 1'b1;
        end else begin
            e.mux = 2'b11; e.busy = 1'b1;
        end
        e.load = r && dv && (m_pos == 0 || m_pos == m_len);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check("mux_sel",   int'(bus_if.mux_sel),   int'(g.mux));
        check("busy",      int'(bus_if.busy),      int'(g.busy));
        check("ser_load",  int'(bus_if.ser_load),  int'(g.load));
        check("ser_shift", int'(bus_if.ser_shift), int'(g.shift));
        check("par_typ_q", int'(bus_if.par_typ_q), int'(g.ptq));
        if (bus_if.busy === 1'b1)      busy_cnt++;
        if (bus_if.ser_shift === 1'b1) shift_cnt++;
        // advance the model to what the coming rising edge produces
        if (r) begin
            if (e.load) begin
                m_pos = 1;
                m_len = DW + 2 + (pe ? 1 : 0);
                m_ptq = pt;
            end else if (m_pos != 0 && m_pos == m_len) begin
                m_pos = 0;
            end else if (m_pos != 0) begin
                m_pos++;
            end
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.DATA_VALID = 1'b0;
        bus_if.PAR_EN     = 1'b0;
        bus_if.PAR_TYP    = 1'b0;

        //                  rst   dv    pe    pt    n   clr busy shift
        segs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  2, 1,  0,  0});  // reset
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  5, 0,  0,  0});  // idle after release
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  1, 1, -1, -1});  // accept, no parity
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 11, 0, 10,  8});
        segs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  1, 1, -1, -1});  // accept, odd parity
        segs.push_back('{1'b1, 1'b0, 1'b1, 1'b1,  2, 0, -1, -1});
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 11, 0, 11,  8});  // settings toggled mid-frame
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  1, 1, -1, -1});  // back-to-back pair
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  9, 0, -1, -1});
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  1, 0, -1, -1});  // accept in STOP
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 11, 0, 20, 16});
        segs.push_back('{1'b1, 1'b1, 1'b1, 1'b0,  1, 1, -1, -1});  // ignored request
        segs.push_back('{1'b1, 1'b0, 1'b1, 1'b0,  4, 0, -1, -1});
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b1,  6, 0, -1, -1});
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  3, 0, 11,  8});
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  1, 1, -1, -1});  // reset mid-frame
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  5, 0, -1, -1});
        segs.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 0,  5,  4});
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  2, 1,  0,  0});
        segs.push_back('{1'b1, 1'b1, 1'b0, 1'b0,  1, 1, -1, -1});  // fresh full frame
        segs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 11, 0, 10,  8});

        foreach (segs[s]) begin
            if (segs[s].clr) begin
                busy_cnt  = 0;
                shift_cnt = 0;
            end
            for (int i = 0; i < segs[s].n; i++) begin
                step(segs[s].rst, segs[s].dv, segs[s].pe, segs[s].pt);
            end
            if (segs[s].exp_busy >= 0) begin
                check($sformatf("seg%0d busy_total", s),  busy_cnt,  segs[s].exp_busy);
                check($sformatf("seg%0d shift_total", s), shift_cnt, segs[s].exp_shift);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
